// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_rx: buffers completed bytes, registered read port,
// occupancy flags and a sticky overrun flag for bytes dropped while full.
module uart_rx_fifo #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_valid_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       rd_valid_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overrun_o,
    input  logic                       overrun_clr_i
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfullCnt = CntW'(AFULL_THRESH);

    typedef enum logic [0:0] {StEmpty, StActive} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overrun_q, overrun_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic rd_accept, wr_accept, overrun_set;

    assign empty_o       = (state_q == StEmpty);
    assign full_o        = (state_q == StActive) && (count_q == DepthCnt);
    assign almost_full_o = (count_q >= AfullCnt);
    assign count_o       = count_q;
    assign rd_data_o     = rd_data_q;
    assign rd_valid_o    = rd_valid_q;
    assign overrun_o     = overrun_q;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_accept   = rd_en_i && !empty_o;
    assign wr_accept   = wr_valid_i && (!full_o || rd_accept);
    assign overrun_set = wr_valid_i && full_o && !rd_accept;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overrun_d  = overrun_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StEmpty: begin
                if (wr_accept) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (rd_accept && !wr_accept && (count_q == CntW'(1))) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StEmpty;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Storage is deliberately left unreset; pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue scoreboard plus a small occupancy/overrun model,
// checked one cycle after every driven cycle.
module tb_uart_rx_fifo;

    localparam int Depth = 16;
    localparam int Afull = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, empty, full, almost_full, overrun;
    logic [4:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb_q[$];
    logic [7:0] m_last_rd = '0;
    logic       m_overrun = 1'b0;

    uart_rx_fifo #(
        .DATA_W       (8),
        .DEPTH        (Depth),
        .AFULL_THRESH (Afull)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_valid_i    (wr_valid),
        .wr_data_i     (wr_data),
        .rd_en_i       (rd_en),
        .rd_data_o     (rd_data),
        .rd_valid_o    (rd_valid),
        .empty_o       (empty),
        .full_o        (full),
        .almost_full_o (almost_full),
        .count_o       (count),
        .overrun_o     (overrun),
        .overrun_clr_i (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        int n;
        n = sb_q.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".full"}, 32'(full), 32'(n == Depth));
        check({tag, ".afull"}, 32'(almost_full), 32'(n >= Afull));
        check({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    // Drives one cycle (called at posedge+1), predicts the result, checks at the next posedge+1.
    task automatic step(input string tag, input logic wv, input logic [7:0] wd, input logic re,
                        input logic clr);
        logic       rd_acc, wr_acc, ov_set;
        logic [7:0] exp_rd;
        int         n;
        n        = sb_q.size();
        rd_acc   = re && (n != 0);
        wr_acc   = wv && ((n < Depth) || rd_acc);
        ov_set   = wv && (n == Depth) && !rd_acc;
        exp_rd   = m_last_rd;
        wr_valid = wv;
        wr_data  = wd;
        rd_en    = re;
        overrun_clr = clr;
        if (rd_acc) exp_rd = sb_q.pop_front();
        if (wr_acc) sb_q.push_back(wd);
        if (clr) m_overrun = 1'b0;
        if (ov_set) m_overrun = 1'b1;
        @(posedge clk);
        #1;
        wr_valid    = 1'b0;
        rd_en       = 1'b0;
        overrun_clr = 1'b0;
        check({tag, ".rd_valid"}, 32'(rd_valid), 32'(rd_acc));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd));
        m_last_rd = exp_rd;
        check_flags(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("reset.count", 32'(count), 32'd0);
        check("reset.empty", 32'(empty), 32'd1);
        check("reset.full", 32'(full), 32'd0);
        check("reset.afull", 32'(almost_full), 32'd0);
        check("reset.rd_valid", 32'(rd_valid), 32'd0);
        check("reset.rd_data", 32'(rd_data), 32'd0);
        check("reset.overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: two bytes, read back in order
        step("t1.wr0", 1'b1, 8'hAA, 1'b0, 1'b0);
        step("t1.wr1", 1'b1, 8'hAB, 1'b0, 1'b0);
        step("t1.rd0", 1'b0, 8'h00, 1'b1, 1'b0);
        step("t1.rd1", 1'b0, 8'h00, 1'b1, 1'b0);
        step("t1.rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        // 2: fill, overrun, set-wins-over-clear, drain
        for (int i = 0; i < Depth; i++) step("t2.fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("t2.ovf", 1'b1, 8'h55, 1'b0, 1'b0);
        step("t2.ovf_clr", 1'b1, 8'h56, 1'b0, 1'b1);
        step("t2.idle", 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < Depth; i++) step("t2.drain", 1'b0, 8'h00, 1'b1, 1'b0);
        step("t2.clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // 3: full with simultaneous read and write
        for (int i = 0; i < Depth; i++) step("t3.fill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step("t3.rw_full", 1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < Depth; i++) step("t3.drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // 4: empty with simultaneous read and write
        step("t4.rw_empty", 1'b1, 8'h3C, 1'b1, 1'b0);
        step("t4.rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // 5: interleaved traffic wrapping the pointers
        for (int i = 0; i < 20; i++) begin
            step("t5.mix", 1'b1, 8'(8'h80 + i), ($urandom_range(0, 2) == 0), 1'b0);
            if ($urandom_range(0, 1) == 1) step("t5.rd", 1'b0, 8'h00, 1'b1, 1'b0);
        end
        while (sb_q.size() != 0) step("t5.drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // 6: asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) step("t6.load", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step("t6.rd", 1'b0, 8'h00, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        sb_q.delete();
        m_overrun = 1'b0;
        m_last_rd = '0;
        check("t6.rst.rd_valid", 32'(rd_valid), 32'd0);
        check("t6.rst.rd_data", 32'(rd_data), 32'd0);
        check_flags("t6.rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("t6.wr", 1'b1, 8'h5A, 1'b0, 1'b0);
        step("t6.rd_after", 1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
